rgb_pwm_fader: RTL and testbench
================================

Name: rgb_pwm_fader

Overview:
Parametrised N-channel LED PWM engine with per-channel fading and breathing.
Replaces the fixed-rate RGB blinker with run-time-programmable duty, target and mode per channel.
Outputs feed the SB_RGBA_DRV PWM inputs (or GPIO LEDs) in the board top level.
Driven from the 12 MHz SB_HFOSC clock.

Parameters:
CHANNELS, 3, number of independent PWM channels (1..8)
WIDTH, 8, duty resolution in bits; PWM period = 2^WIDTH clk cycles
STEP_BITS, 14, fade step interval = 2^STEP_BITS clk cycles per duty LSB step
OUT_INVERT, 0, 1 = pwm_out active-low (per-bit XOR at output register)

Ports:
clk  input  1  system clock (12 MHz)
rst  input  1  asynchronous active-high reset
wr_valid  input  1  configuration write request
wr_ready  output  1  write accepted when wr_valid & wr_ready
wr_ch  input  max(1,$clog2(CHANNELS))  target channel index
wr_mode  input  2  00 OFF, 01 STATIC, 10 FADE, 11 BREATHE
wr_target  input  WIDTH  target / peak duty
pwm_out  output  CHANNELS  registered PWM outputs
done  output  CHANNELS  one-cycle pulse when a FADE reaches its target
duty_mon  output  CHANNELS*WIDTH  current working duty per channel, ch0 in LSBs

Behaviour:
- Reset (async assert, sync release): pwm_cnt=0, step_cnt=0, all duty/duty_active/target=0, mode=OFF, dir=up, done=0, pwm_out={CHANNELS{OUT_INVERT}}, wr_ready=0.
- wr_ready=1 from the first clk after reset release. Always ready thereafter; every write completes in one cycle.
- Write with wr_ch >= CHANNELS: accepted, ignored.
- pwm_cnt: free-running WIDTH-bit counter, +1 per clk, wraps 2^WIDTH-1 -> 0.
- step_tick: 1 clk when the STEP_BITS-bit step_cnt wraps to 0.
- duty_active[c] loads from duty[c] only on the cycle pwm_cnt==2^WIDTH-1, so duty changes never glitch a period.
- Raw PWM per channel:
  - duty_active==0 -> 0.
  - duty_active==2^WIDTH-1 -> constant 1 (full on).
  - Otherwise (pwm_cnt < duty_active).
  - Output is registered: pwm_out reflects pwm_cnt with 1 clk latency.
- Write effects, applied on the accept edge:
  - OFF: duty=0, target=0.
  - STATIC: duty=wr_target immediately.
  - FADE: target=wr_target; duty unchanged.
  - BREATHE: target=wr_target (peak); dir=up; duty unchanged.
- On step_tick, per channel:
  - FADE, duty!=target: duty moves 1 LSB toward target. If it now equals target: done[c] pulses next cycle and mode becomes STATIC.
  - FADE with duty==target on write: done pulses on the next step_tick, mode becomes STATIC.
  - BREATHE: dir up, duty<target -> +1; dir up, duty>=target -> dir=down, duty -1 (duty>0). Dir down, duty>0 -> -1; dir down, duty==0 -> dir=up, +1.
  - BREATHE with target==0: duty held 0, no toggling.
- Write and step_tick on the same channel in the same cycle: the write wins and no step is applied that cycle.
- Duty arithmetic saturates; never wraps below 0 or above 2^WIDTH-1.
- Reset mid-fade: all channels return immediately to the reset state; no done pulse.

Decomposition:
- Package led_pwm_pkg:
  - led_mode_t enum (MODE_OFF, MODE_STATIC, MODE_FADE, MODE_BREATHE).
  - Constant mode encodings.
- Sub-module pwm_channel (one per channel via generate):
  - Holds duty, duty_active, target, mode, dir; drives its raw compare and done.
  - Shared pwm_cnt, step_tick and the per-channel write strobe come from the parent.

Test Plan:
- Reset then idle 2 periods, WIDTH=8, OUT_INVERT=0 -> pwm_out=0, wr_ready=1 from first clk after reset release, duty_mon=0.
- STATIC ch0 target=64 -> starting from the next period, ch0 high exactly 64 of every 256 clks, edges aligned to pwm_cnt wrap; STATIC 255 -> constant high.
- FADE ch1 0->10 with STEP_BITS=4 -> duty_mon ch1 increments by 1 every 16 clks; done[1] single pulse 160±16 clks after write; mode reads back STATIC.
- BREATHE ch2 target=3, STEP_BITS=2 -> duty sequence 0,1,2,3,2,1,0,1,... at 4-clk steps; no done pulse.
- Write FADE target=5 on the step_tick cycle, ch at duty 8 -> no step that cycle; next tick duty=7.
- Assert rst mid-FADE at duty 100 -> pwm_out=OUT_INVERT asynchronously, duty_mon=0, no done; out-of-range wr_ch=3 with CHANNELS=3 -> no state change.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared types for the LED PWM fader: channel mode encodings, fade direction
// and the channel-index width helper.
package led_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_FADE    = 2'b10,
        MODE_BREATHE = 2'b11
    } led_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } led_dir_t;

    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: working duty, period-latched duty, fade/breathe stepping
// and the raw (unregistered) compare against the shared period counter.
module pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pwm_cnt_i,
    input  logic             step_tick_i,
    input  logic             wr_stb_i,
    input  logic [1:0]       wr_mode_i,
    input  logic [WIDTH-1:0] wr_target_i,
    output logic             raw_o,
    output logic             done_o,
    output logic [WIDTH-1:0] duty_o
);

    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] duty_active_q;
    logic [WIDTH-1:0] target_q, target_d;
    led_mode_t        mode_q, mode_d;
    led_dir_t         dir_q, dir_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // A write on this channel takes precedence over a coincident step tick.
    always_comb begin
        duty_d   = duty_q;
        target_d = target_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        if (wr_stb_i) begin
            unique case (led_mode_t'(wr_mode_i))
                MODE_OFF: begin
                    duty_d   = '0;
                    target_d = '0;
                end
                MODE_STATIC:  duty_d = wr_target_i;
                MODE_FADE:    target_d = wr_target_i;
                MODE_BREATHE: begin
                    target_d = wr_target_i;
                    dir_d    = DIR_UP;
                end
            endcase
            mode_d = led_mode_t'(wr_mode_i);
        end else if (step_tick_i) begin
            case (mode_q)
                MODE_FADE: begin
                    if (duty_q < target_q)      duty_d = sat_inc(duty_q);
                    else if (duty_q > target_q) duty_d = sat_dec(duty_q);
                    if (duty_d == target_q) begin
                        done_d = 1'b1;
                        mode_d = MODE_STATIC;
                    end
                end
                MODE_BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (duty_q < target_q) begin
                            duty_d = sat_inc(duty_q);
                        end else if (duty_q != '0) begin
                            dir_d  = DIR_DOWN;
                            duty_d = sat_dec(duty_q);
                        end
                    end else if (duty_q != '0) begin
                        duty_d = sat_dec(duty_q);
                    end else if (target_q != '0) begin
                        dir_d  = DIR_UP;
                        duty_d = sat_inc(duty_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q        <= '0;
            duty_active_q <= '0;
            target_q      <= '0;
            mode_q        <= MODE_OFF;
            dir_q         <= DIR_UP;
            done_q        <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            if (pwm_cnt_i == '1) duty_active_q <= duty_q;
        end
    end

    always_comb begin
        if (duty_active_q == '0)      raw_o = 1'b0;
        else if (duty_active_q == '1) raw_o = 1'b1;
        else                          raw_o = (pwm_cnt_i < duty_active_q);
    end

    assign done_o = done_q;
    assign duty_o = duty_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// N-channel LED PWM engine: shared period/step counters, write decode and the
// registered (optionally inverted) PWM outputs.
module rgb_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int STEP_BITS  = 14,
    parameter int OUT_INVERT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ch_idx_w(CHANNELS)-1:0]   wr_ch,
    input  logic [1:0]                      wr_mode,
    input  logic [WIDTH-1:0]                wr_target,
    output logic [CHANNELS-1:0]             pwm_out,
    output logic [CHANNELS-1:0]             done,
    output logic [CHANNELS*WIDTH-1:0]       duty_mon
);

    localparam int CH_W = ch_idx_w(CHANNELS);
    localparam logic [CHANNELS-1:0] INV_MASK = (OUT_INVERT != 0) ? {CHANNELS{1'b1}} : '0;

    logic [WIDTH-1:0]     pwm_cnt_q;
    logic [STEP_BITS-1:0] step_cnt_q;
    logic                 wr_ready_q;
    logic [CHANNELS-1:0]  pwm_out_q;
    logic [CHANNELS-1:0]  raw;
    logic                 step_tick;
    logic                 wr_fire;

    // The step fires on the edge where step_cnt wraps back to zero.
    assign step_tick = &step_cnt_q;
    assign wr_fire   = wr_valid & wr_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            wr_ready_q <= 1'b0;
            pwm_out_q  <= INV_MASK;
        end else begin
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            step_cnt_q <= step_cnt_q + 1'b1;
            wr_ready_q <= 1'b1;
            pwm_out_q  <= raw ^ INV_MASK;
        end
    end

    // Out-of-range channel indices match no strobe and are silently dropped.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pwm_cnt_i  (pwm_cnt_q),
            .step_tick_i(step_tick),
            .wr_stb_i   (wr_fire && (wr_ch == CH_W'(c))),
            .wr_mode_i  (wr_mode),
            .wr_target_i(wr_target),
            .raw_o      (raw[c]),
            .done_o     (done[c]),
            .duty_o     (duty_mon[c*WIDTH +: WIDTH])
        );
    end

    assign wr_ready = wr_ready_q;
    assign pwm_out  = pwm_out_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader: a per-cycle reference model pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_rgb_pwm_fader;

    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int SB   = 3;
    localparam int INV  = 0;
    localparam int P    = 1 << W;
    localparam int S    = 1 << SB;
    localparam int MAXD = P - 1;
    localparam int OFF  = 0, STAT = 1, FADE = 2, BRTH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [1:0]    wr_ch = '0;
    logic [1:0]    wr_mode = '0;
    logic [W-1:0]  wr_target = '0;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] done;
    logic [CH*W-1:0] duty_mon;

    rgb_pwm_fader #(
        .CHANNELS(CH), .WIDTH(W), .STEP_BITS(SB), .OUT_INVERT(INV)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_target(wr_target),
        .pwm_out(pwm_out), .done(done), .duty_mon(duty_mon)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    typedef struct packed {
        logic [CH-1:0]   pwm;
        logic [CH-1:0]   done;
        logic [CH*W-1:0] duty;
        logic            ready;
    } exp_t;

    exp_t sb[$];

    // Reference model state: plain integers per channel.
    int m_duty[CH];
    int m_act[CH];
    int m_tgt[CH];
    int m_mode[CH];
    int m_up[CH];
    int elapsed = 0;

    always @(posedge clk) begin : model
        exp_t e;
        int   pos;
        bit   tick;
        bit   acc;
        e = '0;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_duty[c] = 0; m_act[c] = 0; m_tgt[c] = 0; m_mode[c] = OFF; m_up[c] = 1;
            end
            elapsed = 0;
            e.pwm   = (INV != 0) ? '1 : '0;
            e.ready = 1'b0;
        end else begin
            pos  = elapsed % P;
            tick = ((elapsed % S) == S - 1);
            acc  = wr_valid && (elapsed > 0);
            for (int c = 0; c < CH; c++) begin
                e.pwm[c] = ((m_act[c] == MAXD) || (m_act[c] != 0 && pos < m_act[c])) ^ (INV != 0);
                if (pos == MAXD) m_act[c] = m_duty[c];
                if (acc && int'(wr_ch) == c) begin
                    case (int'(wr_mode))
                        OFF:  begin m_duty[c] = 0; m_tgt[c] = 0; end
                        STAT: m_duty[c] = int'(wr_target);
                        FADE: m_tgt[c] = int'(wr_target);
                        default: begin m_tgt[c] = int'(wr_target); m_up[c] = 1; end
                    endcase
                    m_mode[c] = int'(wr_mode);
                end else if (tick) begin
                    if (m_mode[c] == FADE) begin
                        if (m_duty[c] < m_tgt[c])      m_duty[c]++;
                        else if (m_duty[c] > m_tgt[c]) m_duty[c]--;
                        if (m_duty[c] == m_tgt[c]) begin
                            e.done[c] = 1'b1;
                            m_mode[c] = STAT;
                        end
                    end else if (m_mode[c] == BRTH) begin
                        if (m_up[c] != 0) begin
                            if (m_duty[c] < m_tgt[c]) m_duty[c]++;
                            else if (m_duty[c] > 0) begin m_up[c] = 0; m_duty[c]--; end
                        end else if (m_duty[c] > 0) begin
                            m_duty[c]--;
                        end else if (m_tgt[c] > 0) begin
                            m_up[c] = 1; m_duty[c]++;
                        end
                    end
                end
            end
            elapsed++;
            e.ready = 1'b1;
        end
        for (int c = 0; c < CH; c++) e.duty[c*W +: W] = W'(m_duty[c]);
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pwm_out", longint'(pwm_out), longint'(e.pwm));
            chk("done", longint'(done), longint'(e.done));
            chk("duty_mon", longint'(duty_mon), longint'(e.duty));
            chk("wr_ready", longint'(wr_ready), longint'(e.ready));
        end
    end

    task automatic wr(input int ch, input int mode, input int tgt);
        @(posedge clk); #1;
        wr_valid  = 1'b1;
        wr_ch     = ch[1:0];
        wr_mode   = mode[1:0];
        wr_target = tgt[W-1:0];
        @(posedge clk); #1;
        wr_valid  = 1'b0;
    endtask

    initial begin : stim
        int hi;
        int lat;
        int ndone;
        int got;
        int prevd;
        int seq[$];
        int bexp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        repeat (2 * P) @(posedge clk);

        // Static duty: exactly 64 high cycles per period, then full-on.
        wr(0, STAT, 64);
        repeat (300) @(negedge clk);
        hi = 0;
        repeat (P) begin @(negedge clk); hi += int'(pwm_out[0]); end
        chk("static64_high_count", hi, 64);

        wr(0, STAT, 255);
        repeat (300) @(negedge clk);
        hi = 0;
        repeat (P) begin @(negedge clk); hi += int'(pwm_out[0]); end
        chk("static255_high_count", hi, P);

        // Fade ch1 0 -> 10: one done pulse after ~10 step intervals.
        wr(1, FADE, 10);
        lat = -1; ndone = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done[1]) begin ndone++; if (lat < 0) lat = i; end
        end
        chk("fade_done_pulses", ndone, 1);
        chk("fade_done_latency_ok", (lat >= 72 && lat <= 90) ? 1 : 0, 1);
        chk("fade_final_duty", longint'(duty_mon[W +: W]), 10);

        // Breathe ch2 peak 3: triangle sequence, never a done pulse.
        wr(2, BRTH, 3);
        prevd = -1; ndone = 0;
        repeat (80) begin
            @(negedge clk);
            got = int'(duty_mon[2*W +: W]);
            if (got != prevd) begin seq.push_back(got); prevd = got; end
            ndone += int'(done[2]);
        end
        for (int i = 0; i < 8; i++)
            chk("breathe_sequence", (i < seq.size()) ? seq[i] : -1, bexp[i]);
        chk("breathe_no_done", ndone, 0);

        // Write FADE on a step-tick cycle: that tick is swallowed.
        wr(0, STAT, 8);
        while ((elapsed % S) != S - 1) begin @(posedge clk); #1; end
        wr_valid = 1'b1; wr_ch = 2'd0; wr_mode = 2'(FADE); wr_target = 8'd5;
        @(posedge clk); #1 wr_valid = 1'b0;
        @(negedge clk);
        chk("tick_write_no_step", longint'(duty_mon[W-1:0]), 8);
        repeat (S) @(posedge clk);
        @(negedge clk);
        chk("tick_write_next_step", longint'(duty_mon[W-1:0]), 7);

        // Out-of-range channel write changes nothing.
        wr(2, OFF, 0);
        repeat (40) @(negedge clk);
        wr(3, STAT, 200);
        @(negedge clk);
        chk("oor_write_ignored", longint'(duty_mon), 24'h000A05);

        // Asynchronous reset in the middle of a fade.
        wr(1, STAT, 150);
        wr(1, FADE, 0);
        got = 0;
        for (int i = 0; i < 2000 && got == 0; i++) begin
            @(negedge clk);
            if (duty_mon[W +: W] == 8'd100) got = 1;
        end
        chk("reach_duty100", got, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_pwm_out", longint'(pwm_out), (INV != 0) ? (1 << CH) - 1 : 0);
        chk("rst_async_duty_mon", longint'(duty_mon), 0);
        chk("rst_async_done", longint'(done), 0);
        chk("rst_async_wr_ready", longint'(wr_ready), 0);
        @(negedge clk); @(negedge clk); #1 rst = 1'b0;

        // Randomized traffic, including boundary targets and bad channels.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge clk); #1 rst = 1'b1;
                @(negedge clk); #1 rst = 1'b0;
            end
            @(posedge clk); #1;
            wr_valid = ($urandom_range(15) == 0);
            wr_ch    = 2'($urandom_range(3));
            wr_mode  = 2'($urandom_range(3));
            case ($urandom_range(3))
                0:       wr_target = '0;
                1:       wr_target = '1;
                2:       wr_target = W'($urandom_range(8));
                default: wr_target = W'($urandom_range(MAXD));
            endcase
        end
        wr_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
